apb_node_tmo: RTL and testbench
===============================

Name: apb_node_tmo

Overview:
Parametrised, registered successor to the combinational APB node. It decodes one upstream APB slave port onto NB_MASTER downstream APB master ports using per-port address windows. Overlapping windows resolve by fixed priority, where the lowest index wins. Unmapped addresses get a decode-error response, and stalled downstream slaves get a timeout-error response. It sits between the SoC APB bridge and the peripheral cluster, where it also breaks the combinational decode path.

Parameters:
NB_MASTER, 8, number of downstream ports (1..32).
APB_DATA_WIDTH, 32, data width; multiple of 8; strobe width is APB_DATA_WIDTH/8.
APB_ADDR_WIDTH, 32, address width.
TIMEOUT_CYCLES, 256, maximum downstream ACCESS cycles before abort; 0 disables the timeout.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
psel_i  in  1  upstream select
penable_i  in  1  upstream enable
pwrite_i  in  1  upstream write
pstrb_i  in  APB_DATA_WIDTH/8  upstream strobes
paddr_i  in  APB_ADDR_WIDTH  upstream address
pwdata_i  in  APB_DATA_WIDTH  upstream write data
prdata_o  out  APB_DATA_WIDTH  upstream read data
pready_o  out  1  upstream ready
pslverr_o  out  1  upstream error
psel_o  out  NB_MASTER  downstream selects (one-hot or zero)
penable_o  out  NB_MASTER  downstream enables
pwrite_o  out  NB_MASTER  downstream write
pstrb_o  out  NB_MASTER x APB_DATA_WIDTH/8  downstream strobes
paddr_o  out  NB_MASTER x APB_ADDR_WIDTH  downstream address
pwdata_o  out  NB_MASTER x APB_DATA_WIDTH  downstream write data
prdata_i  in  NB_MASTER x APB_DATA_WIDTH  downstream read data
pready_i  in  NB_MASTER  downstream ready
pslverr_i  in  NB_MASTER  downstream error
START_ADDR_i  in  NB_MASTER x APB_ADDR_WIDTH  window start (inclusive)
END_ADDR_i  in  NB_MASTER x APB_ADDR_WIDTH  window end (inclusive)
decerr_o  out  1  one-cycle pulse on decode error
tmo_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous and active-high.
- Reset: every output is 0, the FSM is in IDLE, and the counter is 0. Reset asserted mid-transaction aborts immediately; no response is given.
- Registered outputs: all outputs come from flops. Ports that are not selected drive 0 on every signal, including paddr_o, pwdata_o and pstrb_o.
- Decode: match[i] = (START_ADDR_i[i] <= addr <= END_ADDR_i[i]), unsigned. A window with START > END never matches. Overlapping matches select the lowest index.
- FSM states: IDLE, DSETUP, DACCESS, RESP.
- IDLE:
  - On psel_i=1 and penable_i=0, latch addr, write, strb and wdata, plus the decoded index and hit flag.
  - Hit: go to DSETUP.
  - Miss: go to RESP with err=1 and rdata=0; decerr_o pulses with RESP entry.
- DSETUP: psel_o[idx]=1, penable_o=0, latched fields driven on port idx. Next state is DACCESS.
- DACCESS: psel_o[idx]=1 and penable_o[idx]=1.
  - pready_i[idx]=1: capture prdata_i[idx] and pslverr_i[idx], deassert psel_o and penable_o next cycle, go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 without ready, abort: drop psel_o and penable_o, go to RESP with err=1 and rdata=0, and pulse tmo_o.
  - The counter clears on entry to DSETUP.
- RESP:
  - pready_o=1, pslverr_o=err, prdata_o=captured data, for exactly one cycle.
  - Then go to IDLE, and pready_o, pslverr_o and prdata_o return to 0.
  - prdata_o is 0 on writes.
- Upstream latency, with the setup phase at cycle T:
  - Hit with a zero-wait slave: pready_o=1 at T+3.
  - Miss: pready_o=1 at T+1.
  - Each downstream wait state adds one cycle.
- Upstream psel_i dropping while not in IDLE (protocol violation): go to IDLE next cycle, downstream signals forced to 0, no response.
- Back-to-back: a new setup is accepted in the IDLE cycle immediately after RESP.
- Inputs are ignored outside IDLE except psel_i; latched values are held stable downstream.
- With TIMEOUT_CYCLES=0, DACCESS waits indefinitely.

Test Plan:
- Windows 0:[0x1000,0x1FFF], 1:[0x2000,0x2FFF]. Write 0x2004, data 0xA5A5_0001, strb 0xF, zero-wait slave: psel_o=0b10 at T+1, penable_o[1] at T+2, pready_o=1 and pslverr_o=0 at T+3; port 0 outputs all 0.
- Read 0x1FFC, slave 0 returns 0xDEAD_BEEF after 3 wait states: prdata_o=0xDEAD_BEEF with pready_o at T+6, for one cycle only.
- Read 0x9000 (unmapped): no psel_o; pready_o=1, pslverr_o=1, prdata_o=0 and decerr_o=1 at T+1.
- Overlap: port 2 window [0x2000,0x20FF], access to 0x2010: port 1 selected, port 2 untouched.
- TIMEOUT_CYCLES=4, slave never ready: penable_o high for 4 cycles, then dropped; tmo_o=1, pslverr_o=1 and pready_o=1 in RESP.
- Assert rst_i during DACCESS: all outputs 0 immediately. After release, a new transfer completes normally.

Source files
------------

// File: rtl/apb_node_tmo.sv
// apb_node_tmo: registered APB 1-to-N decoder with address windows,
// lowest-index priority on overlap, decode-error and timeout-error responses.
// All outputs leave from flops, so the upstream decode path ends here.

// Per-port lane: window compare plus the registered downstream port.
// A lane that is not selected forces every downstream field to zero.
module apb_node_tmo_lane #(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [AW-1:0]   i_start,
  input  logic [AW-1:0]   i_end,
  input  logic [AW-1:0]   i_dec_addr,
  output logic            o_match,
  input  logic            i_sel,
  input  logic            i_en,
  input  logic            i_write,
  input  logic [DW/8-1:0] i_strb,
  input  logic [AW-1:0]   i_addr,
  input  logic [DW-1:0]   i_wdata,
  output logic            o_psel,
  output logic            o_penable,
  output logic            o_pwrite,
  output logic [DW/8-1:0] o_pstrb,
  output logic [AW-1:0]   o_paddr,
  output logic [DW-1:0]   o_pwdata
);
  logic            r_psel, r_penable, r_pwrite;
  logic [DW/8-1:0] r_pstrb;
  logic [AW-1:0]   r_paddr;
  logic [DW-1:0]   r_pwdata;

  // Inclusive unsigned window; START > END naturally never matches.
  assign o_match = (i_dec_addr >= i_start) && (i_dec_addr <= i_end);

  // Downstream port register: fields only carry data while this port is selected.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_pstrb   <= '0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
    end else begin
      r_psel    <= i_sel;
      r_penable <= i_sel & i_en;
      r_pwrite  <= i_sel & i_write;
      r_pstrb   <= i_sel ? i_strb  : '0;
      r_paddr   <= i_sel ? i_addr  : '0;
      r_pwdata  <= i_sel ? i_wdata : '0;
    end
  end

  assign o_psel    = r_psel;
  assign o_penable = r_penable;
  assign o_pwrite  = r_pwrite;
  assign o_pstrb   = r_pstrb;
  assign o_paddr   = r_paddr;
  assign o_pwdata  = r_pwdata;
endmodule

module apb_node_tmo #(
  parameter int NB_MASTER      = 8,
  parameter int APB_DATA_WIDTH = 32,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          psel_i,
  input  logic                                          penable_i,
  input  logic                                          pwrite_i,
  input  logic [APB_DATA_WIDTH/8-1:0]                   pstrb_i,
  input  logic [APB_ADDR_WIDTH-1:0]                     paddr_i,
  input  logic [APB_DATA_WIDTH-1:0]                     pwdata_i,
  output logic [APB_DATA_WIDTH-1:0]                     prdata_o,
  output logic                                          pready_o,
  output logic                                          pslverr_o,
  output logic [NB_MASTER-1:0]                          psel_o,
  output logic [NB_MASTER-1:0]                          penable_o,
  output logic [NB_MASTER-1:0]                          pwrite_o,
  output logic [NB_MASTER-1:0][APB_DATA_WIDTH/8-1:0]    pstrb_o,
  output logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0]      paddr_o,
  output logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0]      pwdata_o,
  input  logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0]      prdata_i,
  input  logic [NB_MASTER-1:0]                          pready_i,
  input  logic [NB_MASTER-1:0]                          pslverr_i,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0]      START_ADDR_i,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0]      END_ADDR_i,
  output logic                                          decerr_o,
  output logic                                          tmo_o
);
  localparam int DW    = APB_DATA_WIDTH;
  localparam int AW    = APB_ADDR_WIDTH;
  localparam int SW    = APB_DATA_WIDTH / 8;
  localparam int IDX_W = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_DSETUP, S_DACCESS, S_RESP} state_t;

  state_t           r_state, w_state_nxt;
  logic [AW-1:0]    r_addr;
  logic             r_write;
  logic [SW-1:0]    r_strb;
  logic [DW-1:0]    r_wdata;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic [DW-1:0]    r_prdata;
  logic             r_pready, r_pslverr, r_decerr, r_tmo;

  logic [NB_MASTER-1:0] w_match;
  logic                 w_hit;
  logic [IDX_W-1:0]     w_dec_idx;

  logic             w_latch;
  logic             w_err_nxt, w_decerr_nxt, w_tmo_nxt;
  logic [DW-1:0]    w_rdata_nxt;

  logic             w_dn_sel, w_dn_en;
  logic [IDX_W-1:0] w_dn_idx;
  logic [AW-1:0]    w_f_addr;
  logic             w_f_write;
  logic [SW-1:0]    w_f_strb;
  logic [DW-1:0]    w_f_wdata;

  logic             w_sel_ready, w_sel_err;
  logic [DW-1:0]    w_sel_rdata;

  // Lowest matching index wins; scan downwards so index 0 overwrites last.
  always_comb begin
    w_hit     = |w_match;
    w_dec_idx = '0;
    for (int i = NB_MASTER - 1; i >= 0; i--) begin
      if (w_match[i]) w_dec_idx = IDX_W'(i);
    end
  end

  assign w_sel_ready = pready_i[r_idx];
  assign w_sel_err   = pslverr_i[r_idx];
  assign w_sel_rdata = prdata_i[r_idx];

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state plus the values the response flops load on RESP entry.
  always_comb begin
    w_state_nxt  = r_state;
    w_latch      = 1'b0;
    w_cnt_nxt    = r_cnt;
    w_err_nxt    = 1'b0;
    w_rdata_nxt  = '0;
    w_decerr_nxt = 1'b0;
    w_tmo_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (psel_i && !penable_i) begin
          w_latch = 1'b1;
          if (w_hit) begin
            w_state_nxt = S_DSETUP;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt  = S_RESP;
            w_err_nxt    = 1'b1;
            w_decerr_nxt = 1'b1;
          end
        end
      end
      S_DSETUP: begin
        w_state_nxt = psel_i ? S_DACCESS : S_IDLE;
      end
      S_DACCESS: begin
        if (!psel_i) begin
          w_state_nxt = S_IDLE;
        end else if (w_sel_ready) begin
          w_state_nxt = S_RESP;
          w_err_nxt   = w_sel_err;
          w_rdata_nxt = r_write ? '0 : w_sel_rdata;
        end else if (TMO_EN && (r_cnt == TMO_LAST)) begin
          w_state_nxt = S_RESP;
          w_err_nxt   = 1'b1;
          w_tmo_nxt   = 1'b1;
        end else if (TMO_EN) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Request capture and the ACCESS wait counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_strb  <= '0;
      r_wdata <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_latch) begin
        r_addr  <= paddr_i;
        r_write <= pwrite_i;
        r_strb  <= pstrb_i;
        r_wdata <= pwdata_i;
        r_idx   <= w_dec_idx;
      end
    end
  end

  // Upstream response flops: nonzero only during the single RESP cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      r_decerr  <= 1'b0;
      r_tmo     <= 1'b0;
    end else begin
      r_pready  <= (w_state_nxt == S_RESP);
      r_pslverr <= w_err_nxt;
      r_prdata  <= w_rdata_nxt;
      r_decerr  <= w_decerr_nxt;
      r_tmo     <= w_tmo_nxt;
    end
  end

  // Downstream drive for the coming cycle; on the accept cycle the fields
  // bypass the capture registers so DSETUP appears one cycle after setup.
  assign w_dn_sel  = (w_state_nxt == S_DSETUP) || (w_state_nxt == S_DACCESS);
  assign w_dn_en   = (w_state_nxt == S_DACCESS);
  assign w_dn_idx  = w_latch ? w_dec_idx : r_idx;
  assign w_f_addr  = w_latch ? paddr_i   : r_addr;
  assign w_f_write = w_latch ? pwrite_i  : r_write;
  assign w_f_strb  = w_latch ? pstrb_i   : r_strb;
  assign w_f_wdata = w_latch ? pwdata_i  : r_wdata;

  for (genvar g = 0; g < NB_MASTER; g++) begin : g_lane
    apb_node_tmo_lane #(.DW(DW), .AW(AW)) u_lane (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .i_start    (START_ADDR_i[g]),
      .i_end      (END_ADDR_i[g]),
      .i_dec_addr (paddr_i),
      .o_match    (w_match[g]),
      .i_sel      (w_dn_sel && (w_dn_idx == IDX_W'(g))),
      .i_en       (w_dn_en),
      .i_write    (w_f_write),
      .i_strb     (w_f_strb),
      .i_addr     (w_f_addr),
      .i_wdata    (w_f_wdata),
      .o_psel     (psel_o[g]),
      .o_penable  (penable_o[g]),
      .o_pwrite   (pwrite_o[g]),
      .o_pstrb    (pstrb_o[g]),
      .o_paddr    (paddr_o[g]),
      .o_pwdata   (pwdata_o[g])
    );
  end

  assign prdata_o  = r_prdata;
  assign pready_o  = r_pready;
  assign pslverr_o = r_pslverr;
  assign decerr_o  = r_decerr;
  assign tmo_o     = r_tmo;
endmodule

// File: tb/tb_apb_node_tmo.sv
// Directed bench for apb_node_tmo: four ports, timeout of 4 ACCESS cycles.
module tb_apb_node_tmo;
  localparam int NB = 4;

  logic                     clk_i, rst_i;
  logic                     psel_i, penable_i, pwrite_i;
  logic [3:0]               pstrb_i;
  logic [31:0]              paddr_i, pwdata_i;
  logic [31:0]              prdata_o;
  logic                     pready_o, pslverr_o;
  logic [NB-1:0]            psel_o, penable_o, pwrite_o;
  logic [NB-1:0][3:0]       pstrb_o;
  logic [NB-1:0][31:0]      paddr_o, pwdata_o;
  logic [NB-1:0][31:0]      prdata_i;
  logic [NB-1:0]            pready_i, pslverr_i;
  logic [NB-1:0][31:0]      START_ADDR_i, END_ADDR_i;
  logic                     decerr_o, tmo_o;

  int total = 0;
  int bad   = 0;

  // Simple slaves: each port is ready after waits[i] ACCESS wait states.
  logic [NB-1:0][7:0]  waits;
  logic [NB-1:0][7:0]  wcnt;
  logic [NB-1:0][31:0] rcfg;
  logic [NB-1:0]       ecfg;

  apb_node_tmo #(
    .NB_MASTER(NB), .APB_DATA_WIDTH(32), .APB_ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .psel_i(psel_i), .penable_i(penable_i),
    .pwrite_i(pwrite_i), .pstrb_i(pstrb_i), .paddr_i(paddr_i), .pwdata_i(pwdata_i),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .pstrb_o(pstrb_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i),
    .pslverr_i(pslverr_i), .START_ADDR_i(START_ADDR_i), .END_ADDR_i(END_ADDR_i),
    .decerr_o(decerr_o), .tmo_o(tmo_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always_comb begin
    pready_i  = '0;
    prdata_i  = '0;
    pslverr_i = '0;
    for (int i = 0; i < NB; i++) begin
      pready_i[i]  = psel_o[i] & penable_o[i] & (wcnt[i] >= waits[i]);
      prdata_i[i]  = rcfg[i];
      pslverr_i[i] = ecfg[i];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NB; i++) begin
      if (!penable_o[i])       wcnt[i] <= '0;
      else if (!pready_i[i])   wcnt[i] <= wcnt[i] + 8'd1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic setup(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    psel_i    = 1'b1;
    penable_i = 1'b0;
    pwrite_i  = wr;
    paddr_i   = addr;
    pwdata_i  = data;
    pstrb_i   = 4'hF;
  endtask

  task automatic idle_bus();
    psel_i    = 1'b0;
    penable_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    psel_i = 0; penable_i = 0; pwrite_i = 0; pstrb_i = 0; paddr_i = 0; pwdata_i = 0;
    waits = '0; rcfg = '0; ecfg = '0;
    START_ADDR_i[0] = 32'h1000; END_ADDR_i[0] = 32'h1FFF;
    START_ADDR_i[1] = 32'h2000; END_ADDR_i[1] = 32'h2FFF;
    START_ADDR_i[2] = 32'h2000; END_ADDR_i[2] = 32'h20FF;
    START_ADDR_i[3] = 32'h5000; END_ADDR_i[3] = 32'h4000;
    step(); step();
    chk("rst_psel", psel_o, 0);
    chk("rst_pready", pready_o, 0);
    chk("rst_prdata", prdata_o, 0);
    rst_i = 1'b0;
    step();

    // Write to port 1, zero-wait slave.
    setup(1'b1, 32'h2004, 32'hA5A5_0001);
    step();                                  // T+1
    chk("wr_psel", psel_o, 4'b0010);
    chk("wr_pen_setup", penable_o, 0);
    chk("wr_paddr1", paddr_o[1], 32'h2004);
    chk("wr_pwdata1", pwdata_o[1], 32'hA5A5_0001);
    chk("wr_pwrite", pwrite_o, 4'b0010);
    chk("wr_pstrb1", pstrb_o[1], 4'hF);
    chk("wr_port0_zero", {paddr_o[0], pwdata_o[0], pstrb_o[0]}, 0);
    penable_i = 1'b1;
    step();                                  // T+2
    chk("wr_penable", penable_o, 4'b0010);
    chk("wr_pready_early", pready_o, 0);
    step();                                  // T+3
    chk("wr_pready", pready_o, 1);
    chk("wr_pslverr", pslverr_o, 0);
    chk("wr_prdata", prdata_o, 0);
    chk("wr_psel_drop", psel_o, 0);
    idle_bus();
    step();
    chk("wr_pready_gone", pready_o, 0);

    // Read port 0 near window end, three wait states.
    waits[0] = 8'd3; rcfg[0] = 32'hDEAD_BEEF;
    setup(1'b0, 32'h1FFC, 32'h0);
    step();                                  // T+1
    chk("rd_psel", psel_o, 4'b0001);
    penable_i = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      step();
      chk($sformatf("rd_wait_T%0d", k), {penable_o, 3'b0, pready_o}, {4'b0001, 4'b0000});
    end
    step();                                  // T+6
    chk("rd_pready", pready_o, 1);
    chk("rd_prdata", prdata_o, 32'hDEAD_BEEF);
    chk("rd_pslverr", pslverr_o, 0);
    idle_bus();
    step();
    chk("rd_one_cycle", {pready_o, prdata_o}, 0);

    // Unmapped address.
    setup(1'b0, 32'h9000, 32'h0);
    step();                                  // T+1
    chk("miss_psel", psel_o, 0);
    chk("miss_resp", {pready_o, pslverr_o, decerr_o}, 3'b111);
    chk("miss_prdata", prdata_o, 0);
    idle_bus();
    step();
    chk("miss_pulse", {pready_o, decerr_o}, 0);

    // Port 3 has START > END: never matches.
    setup(1'b1, 32'h4800, 32'h1);
    step();
    chk("inv_win_psel", psel_o, 0);
    chk("inv_win_decerr", decerr_o, 1);
    idle_bus();
    step();

    // Overlap: port 1 beats port 2; slave error propagates.
    rcfg[1] = 32'h1111_2222; ecfg[1] = 1'b1;
    setup(1'b0, 32'h2010, 32'h0);
    step();
    chk("ovl_psel", psel_o, 4'b0010);
    chk("ovl_port2_addr", paddr_o[2], 0);
    penable_i = 1'b1;
    step();
    chk("ovl_penable", penable_o, 4'b0010);
    step();
    chk("ovl_prdata", prdata_o, 32'h1111_2222);
    chk("ovl_pslverr", {pready_o, pslverr_o}, 2'b11);
    idle_bus();
    ecfg[1] = 1'b0;
    step();

    // Timeout on port 1 (0x2100 is outside port 2's window).
    waits[1] = 8'd255;
    setup(1'b1, 32'h2100, 32'h5);
    step();                                  // T+1
    chk("tmo_psel", psel_o, 4'b0010);
    penable_i = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      step();
      chk($sformatf("tmo_pen_T%0d", k), {penable_o, pready_o}, {4'b0010, 1'b0});
    end
    step();                                  // T+6
    chk("tmo_dropped", {psel_o, penable_o}, 0);
    chk("tmo_resp", {pready_o, pslverr_o, tmo_o, decerr_o}, 4'b1110);
    chk("tmo_prdata", prdata_o, 0);
    idle_bus();
    step();
    chk("tmo_pulse", {tmo_o, pready_o}, 0);
    waits[1] = 8'd0;

    // Upstream psel drops during DSETUP: abort, no response.
    setup(1'b0, 32'h1004, 32'h0);
    step();
    chk("viol_psel", psel_o, 4'b0001);
    idle_bus();
    step();
    chk("viol_abort", {psel_o, penable_o, pready_o}, 0);
    step();
    chk("viol_no_resp", pready_o, 0);

    // Reset during DACCESS, then a clean transfer.
    waits[0] = 8'd3;
    setup(1'b0, 32'h1000, 32'h0);
    step();
    penable_i = 1'b1;
    step();                                  // DACCESS
    chk("pre_rst_pen", penable_o, 4'b0001);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_outs", {psel_o, penable_o, pready_o, pslverr_o, tmo_o, decerr_o}, 0);
    chk("mid_rst_paddr", paddr_o[0], 0);
    step();
    idle_bus();
    rst_i = 1'b0;
    waits[0] = 8'd0; rcfg[0] = 32'h0BAD_F00D;
    step();
    setup(1'b0, 32'h1000, 32'h0);
    step();
    chk("post_rst_psel", psel_o, 4'b0001);
    penable_i = 1'b1;
    step();
    step();
    chk("post_rst_resp", {pready_o, pslverr_o}, 2'b10);
    chk("post_rst_prdata", prdata_o, 32'h0BAD_F00D);
    idle_bus();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
